pulse_framer: RTL and testbench

// - Upstream stage of pulse_avg_core, ce_clk domain.
// - Input: AXI-stream of 32-bit samples from the axi_wrapper m_axis_data port.
// - On arm: waits for a packet start, then cuts the stream into num_avg pulses of pulse_size samples each.
// - Marks the last sample of every pulse with o_tlast and feeds the averager. Samples outside an armed run are discarded.

---
 rtl/pulse_framer.sv | 242 ++++++++++++++++++++++++
 tb/tb_pulse_framer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_framer.sv
// Pulse framer ahead of pulse_avg_core: once armed, waits for a packet start and cuts the
// sample stream into num_avg pulses of pulse_size samples, flagging each pulse end with o_tlast.
module pulse_framer #(
    parameter int MAX_PULSE_SIZE = 8192,
    parameter int WIDTH          = 32,
    parameter int USER_W         = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              arm,
    input  logic [31:0]       pulse_size,
    input  logic [31:0]       num_avg,
    input  logic [WIDTH-1:0]  i_tdata,
    input  logic [USER_W-1:0] i_tuser,
    input  logic              i_tvalid,
    input  logic              i_tlast,
    output logic              i_tready,
    output logic [WIDTH-1:0]  o_tdata,
    output logic [USER_W-1:0] o_tuser,
    output logic              o_tvalid,
    output logic              o_tlast,
    input  logic              o_tready,
    output logic              busy,
    output logic [31:0]       pulse_count
);

    localparam int CNT_W = $clog2(MAX_PULSE_SIZE) + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOP = 2'd1,
        ST_FRAME    = 2'd2
    } state_t;

    state_t              state_r;
    logic                busy_r;
    logic [CNT_W-1:0]    ps_r;
    logic [31:0]         na_r;
    logic [CNT_W-1:0]    samp_cnt_r;
    logic [31:0]         pulse_count_r;
    logic                sop_flag_r;
    logic [WIDTH-1:0]    o_tdata_r;
    logic [USER_W-1:0]   o_tuser_r;
    logic                o_tvalid_r;
    logic                o_tlast_r;

    logic                ready_s;
    logic                accept_s;
    logic                out_fire_s;
    logic                last_pulse_s;
    logic                last_pending_s;
    logic                last_samp_s;
    logic                first_s;
    logic [CNT_W-1:0]    samp_next_s;
    logic                start_s;
    logic                load_s;
    logic                tlast_fire_s;
    logic                done_s;
    logic                drain_s;

    function automatic logic [CNT_W-1:0] clamp_ps(input logic [31:0] val);
        logic [CNT_W-1:0] res;
        if (val == 32'd0) begin
            res = CNT_W'(1);
        end else if (val > 32'(MAX_PULSE_SIZE)) begin
            res = CNT_W'(MAX_PULSE_SIZE);
        end else begin
            res = val[CNT_W-1:0];
        end
        return res;
    endfunction

    function automatic logic [31:0] clamp_na(input logic [31:0] val);
        logic [31:0] res;
        if (val == 32'd0) begin
            res = 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Handshake and counter decode
    always_comb begin
        out_fire_s     = o_tvalid_r & o_tready;
        last_pulse_s   = ((pulse_count_r + 32'd1) == na_r);
        // Holding the final beat of the run: accept nothing more until it leaves.
        last_pending_s = o_tvalid_r & o_tlast_r & last_pulse_s;
        last_samp_s    = (samp_cnt_r == (ps_r - CNT_W'(1)));
        first_s        = (samp_cnt_r == {CNT_W{1'b0}});
        if (last_samp_s) begin
            samp_next_s = {CNT_W{1'b0}};
        end else begin
            samp_next_s = samp_cnt_r + CNT_W'(1);
        end
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE:     ready_s = 1'b1;
            ST_WAIT_SOP: ready_s = 1'b1;
            ST_FRAME:    ready_s = (~o_tvalid_r | o_tready) & ~last_pending_s;
            default:     ready_s = 1'b0;
        endcase
        accept_s = i_tvalid & ready_s;
    end

    // Control strobes; clear suppresses every action
    always_comb begin
        start_s      = 1'b0;
        load_s       = 1'b0;
        tlast_fire_s = 1'b0;
        done_s       = 1'b0;
        drain_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = arm & ~clear;
            end
            ST_WAIT_SOP: begin
                load_s = accept_s & sop_flag_r & ~clear;
            end
            ST_FRAME: begin
                load_s       = accept_s & ~clear;
                tlast_fire_s = out_fire_s & o_tlast_r & ~clear;
                done_s       = tlast_fire_s & last_pulse_s;
                drain_s      = out_fire_s & ~accept_s & ~clear;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Run state machine and busy flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else if (clear) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_WAIT_SOP;
                        busy_r  <= 1'b1;
                    end
                end
                ST_WAIT_SOP: begin
                    if (load_s) begin
                        state_r <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (done_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Run configuration, frozen for the duration of a run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_r <= CNT_W'(1);
            na_r <= 32'd1;
        end else if (start_s) begin
            ps_r <= clamp_ps(pulse_size);
            na_r <= clamp_na(num_avg);
        end
    end

    // Packet-start tracking over every accepted beat, armed or not
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sop_flag_r <= 1'b1;
        end else if (accept_s) begin
            sop_flag_r <= i_tlast;
        end
    end

    // Sample index within the current pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_cnt_r <= {CNT_W{1'b0}};
        end else if (clear || done_s || start_s) begin
            samp_cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            samp_cnt_r <= samp_next_s;
        end
    end

    // Pulses handed downstream in the current or most recent run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_count_r <= 32'd0;
        end else if (start_s) begin
            pulse_count_r <= 32'd0;
        end else if (tlast_fire_s) begin
            pulse_count_r <= pulse_count_r + 32'd1;
        end
    end

    // Single output register stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_tdata_r  <= {WIDTH{1'b0}};
            o_tuser_r  <= {USER_W{1'b0}};
            o_tvalid_r <= 1'b0;
            o_tlast_r  <= 1'b0;
        end else if (clear || done_s) begin
            o_tvalid_r <= 1'b0;
            o_tlast_r  <= 1'b0;
        end else if (load_s) begin
            o_tdata_r  <= i_tdata;
            o_tvalid_r <= 1'b1;
            o_tlast_r  <= last_samp_s;
            // The pulse keeps the header of its first sample.
            if (first_s) begin
                o_tuser_r <= i_tuser;
            end
        end else if (drain_s) begin
            o_tvalid_r <= 1'b0;
            o_tlast_r  <= 1'b0;
        end
    end

    assign i_tready    = ready_s;
    assign o_tdata     = o_tdata_r;
    assign o_tuser     = o_tuser_r;
    assign o_tvalid    = o_tvalid_r;
    assign o_tlast     = o_tlast_r;
    assign busy        = busy_r;
    assign pulse_count = pulse_count_r;

endmodule

// File: tb/tb_pulse_framer.sv
// Bench for pulse_framer: random sample data and backpressure, checked against a
// beat-level reference model that cuts the accepted input stream into pulses.
module tb_pulse_framer;

    localparam int WIDTH  = 32;
    localparam int USER_W = 128;
    localparam int MAXPS  = 8192;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              clear = 1'b0;
    logic              arm = 1'b0;
    logic [31:0]       pulse_size = 32'd0;
    logic [31:0]       num_avg = 32'd0;
    logic [WIDTH-1:0]  i_tdata = '0;
    logic [USER_W-1:0] i_tuser = '0;
    logic              i_tvalid = 1'b0;
    logic              i_tlast = 1'b0;
    logic              i_tready;
    logic [WIDTH-1:0]  o_tdata;
    logic [USER_W-1:0] o_tuser;
    logic              o_tvalid;
    logic              o_tlast;
    logic              o_tready = 1'b1;
    logic              busy;
    logic [31:0]       pulse_count;

    pulse_framer #(.MAX_PULSE_SIZE(MAXPS), .WIDTH(WIDTH), .USER_W(USER_W)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .arm(arm),
        .pulse_size(pulse_size), .num_avg(num_avg),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tvalid(i_tvalid), .i_tlast(i_tlast),
        .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
        .o_tready(o_tready), .busy(busy), .pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0]  d;
        logic [USER_W-1:0] u;
        logic              l;
    } beat_t;

    beat_t exp_q[$];
    int total = 0;
    int bad = 0;

    // reference model state
    bit              m_armed = 1'b0;
    bit              m_in_frame = 1'b0;
    bit              m_sop = 1'b1;
    bit              m_busy = 1'b0;
    int              m_ps = 1;
    int unsigned     m_na = 1;
    int              m_idx = 0;
    int unsigned     m_taken = 0;
    int unsigned     m_pc = 0;
    logic [USER_W-1:0] m_user = '0;

    int    rdy_mode = 0;
    int    out_beats = 0;
    int    out_lasts = 0;
    int    pos_g = 0;
    int    pkt_len_g = 12;
    bit    prev_stall = 1'b0;
    beat_t prev_b;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int clamp_ps(input logic [31:0] v);
        if (v == 32'd0) return 1;
        if (v > 32'(MAXPS)) return MAXPS;
        return int'(v);
    endfunction

    // Accepted input beat: forwarded only while armed and once a packet start was seen.
    task automatic model_accept(input beat_t b);
        beat_t e;
        if (m_armed && (m_in_frame || m_sop)) begin
            m_in_frame = 1'b1;
            if (m_idx == 0) m_user = b.u;
            e.d = b.d;
            e.u = m_user;
            e.l = (m_idx == m_ps - 1);
            exp_q.push_back(e);
            m_idx = (m_idx + 1) % m_ps;
            if (e.l) begin
                m_taken++;
                if (m_taken == m_na) m_armed = 1'b0;
            end
        end
        m_sop = b.l;
    endtask

    // One clock: check outputs at the falling edge, update the model, advance past the rising edge.
    task automatic step(output bit in_acc);
        beat_t cur;
        beat_t e;
        bit out_acc;
        bit was_busy;
        @(negedge clk);
        chk("busy", busy, m_busy);
        chk("pulse_count", pulse_count, m_pc);
        if (prev_stall) begin
            chk("stall_valid", o_tvalid, 1'b1);
            chk("stall_beat", {o_tdata, o_tuser, o_tlast}, prev_b);
        end
        out_acc  = o_tvalid && o_tready;
        in_acc   = i_tvalid && i_tready;
        was_busy = m_busy;
        if (out_acc) begin
            out_beats++;
            if (o_tlast) out_lasts++;
            chk("out_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_beat", {o_tdata, o_tuser, o_tlast}, e);
                if (e.l && !clear) begin
                    m_pc++;
                    if (m_pc == m_na) m_busy = 1'b0;
                end
            end
        end
        if (clear) begin
            m_armed = 1'b0;
            m_in_frame = 1'b0;
            m_busy = 1'b0;
            exp_q.delete();
        end
        if (in_acc) begin
            cur.d = i_tdata;
            cur.u = i_tuser;
            cur.l = i_tlast;
            model_accept(cur);
        end
        if (arm && !clear && !was_busy) begin
            m_ps = clamp_ps(pulse_size);
            m_na = (num_avg == 32'd0) ? 1 : num_avg;
            m_armed = 1'b1;
            m_in_frame = 1'b0;
            m_idx = 0;
            m_taken = 0;
            m_pc = 0;
            m_busy = 1'b1;
        end
        prev_stall = o_tvalid && !o_tready && !clear;
        prev_b = {o_tdata, o_tuser, o_tlast};
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       o_tready = 1'b1;
            1:       o_tready = !o_tready;
            default: o_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send_beats(input int n);
        bit acc;
        int waitc;
        for (int k = 0; k < n; k++) begin
            i_tvalid = 1'b1;
            i_tdata  = $urandom;
            i_tuser  = {$urandom, $urandom, $urandom, $urandom};
            i_tlast  = (pos_g == pkt_len_g - 1);
            acc = 1'b0;
            waitc = 0;
            while (!acc && waitc < 64) begin
                step(acc);
                waitc++;
            end
            chk("in_accept", acc, 1'b1);
            pos_g = (pos_g + 1) % pkt_len_g;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        bit a;
        for (int k = 0; k < n; k++) step(a);
    endtask

    task automatic drain(input int n);
        rdy_mode = 0;
        i_tvalid = 1'b0;
        idle_steps(n);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_arm(input logic [31:0] ps, input logic [31:0] na);
        bit a;
        pulse_size = ps;
        num_avg = na;
        arm = 1'b1;
        step(a);
        arm = 1'b0;
    endtask

    initial begin
        bit a;
        // reset state
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_tvalid", o_tvalid, 1'b0);
        chk("rst_tlast", o_tlast, 1'b0);
        chk("rst_tdata", o_tdata, 0);
        chk("rst_tuser", o_tuser, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pc", pulse_count, 0);
        chk("rst_tready", i_tready, 1'b1);

        // ps=4 na=2 on a 12-beat packet
        out_beats = 0; out_lasts = 0; pkt_len_g = 12; pos_g = 0;
        do_arm(32'd4, 32'd2);
        send_beats(12);
        drain(10);
        chk("s1_beats", out_beats, 8);
        chk("s1_lasts", out_lasts, 2);
        chk("s1_pc", pulse_count, 2);

        // arm mid-packet: output starts at the next packet
        out_beats = 0; out_lasts = 0; pkt_len_g = 5;
        send_beats(2);
        do_arm(32'd3, 32'd1);
        send_beats(8);
        drain(10);
        chk("s2_beats", out_beats, 3);
        chk("s2_lasts", out_lasts, 1);

        // toggling backpressure, ps=8 na=3
        out_beats = 0; out_lasts = 0; pkt_len_g = 30;
        rdy_mode = 1;
        do_arm(32'd8, 32'd3);
        send_beats(30);
        drain(10);
        chk("s3_beats", out_beats, 24);
        chk("s3_lasts", out_lasts, 3);
        chk("s3_pc", pulse_count, 3);

        // pulse_size=0, num_avg=0 -> one single-sample pulse
        out_beats = 0; out_lasts = 0; pkt_len_g = 4;
        do_arm(32'd0, 32'd0);
        send_beats(4);
        drain(10);
        chk("s4_beats", out_beats, 1);
        chk("s4_lasts", out_lasts, 1);
        chk("s4_pc", pulse_count, 1);

        // pulse_size=20000 clamps to the maximum, random backpressure
        out_beats = 0; out_lasts = 0; pkt_len_g = 8200;
        rdy_mode = 2;
        do_arm(32'd20000, 32'd0);
        send_beats(8200);
        drain(10);
        chk("s5_beats", out_beats, MAXPS);
        chk("s5_lasts", out_lasts, 1);
        chk("s5_pc", pulse_count, 1);

        // clear in the middle of the second pulse
        out_beats = 0; out_lasts = 0; pkt_len_g = 20;
        do_arm(32'd10, 32'd2);
        send_beats(15);
        clear = 1'b1;
        step(a);
        clear = 1'b0;
        chk("clr_tvalid", o_tvalid, 1'b0);
        chk("clr_busy", busy, 1'b0);
        chk("clr_pc", pulse_count, 1);
        send_beats(5);
        pulse_size = 32'd3;
        arm = 1'b1;
        clear = 1'b1;
        step(a);
        arm = 1'b0;
        clear = 1'b0;
        chk("armclr_busy", busy, 1'b0);
        chk("armclr_pc", pulse_count, 1);
        out_beats = 0; out_lasts = 0;
        do_arm(32'd10, 32'd1);
        send_beats(20);
        drain(10);
        chk("s6_beats", out_beats, 10);
        chk("s6_lasts", out_lasts, 1);
        chk("s6_pc", pulse_count, 1);

        // asynchronous reset mid-run
        pkt_len_g = 16;
        do_arm(32'd6, 32'd2);
        send_beats(4);
        reset_n = 1'b0;
        #1;
        chk("arst_tvalid", o_tvalid, 1'b0);
        chk("arst_tlast", o_tlast, 1'b0);
        chk("arst_tdata", o_tdata, 0);
        chk("arst_tuser", o_tuser, 0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_pc", pulse_count, 0);
        m_armed = 1'b0; m_in_frame = 1'b0; m_sop = 1'b1; m_busy = 1'b0; m_pc = 0;
        exp_q.delete();
        prev_stall = 1'b0;
        pos_g = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // arm while busy is ignored
        out_beats = 0; out_lasts = 0;
        do_arm(32'd4, 32'd1);
        send_beats(2);
        pulse_size = 32'd2;
        num_avg = 32'd5;
        arm = 1'b1;
        step(a);
        arm = 1'b0;
        send_beats(6);
        drain(10);
        chk("s7_beats", out_beats, 4);
        chk("s7_lasts", out_lasts, 1);
        chk("s7_pc", pulse_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
